// File: rtl/bdd_pkg.sv
// Shared types and constants for the BDD node-table datapath.
// Node word layout, default SRAM geometry, arbiter state encodings.
package bdd_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 34;

  localparam int FLD0_LSB = 26;
  localparam int FLD1_LSB = 18;
  localparam int FLD2_LSB = 10;
  localparam int FLD3_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  function automatic logic [DEF_DATA_WIDTH-1:0] node_word(
    input logic [7:0] f0,
    input logic [7:0] f1,
    input logic [7:0] f2,
    input logic [9:0] f3
  );
    logic [DEF_DATA_WIDTH-1:0] w;
    w = '0;
    w[FLD0_LSB +: 8]  = f0;
    w[FLD1_LSB +: 8]  = f1;
    w[FLD2_LSB +: 8]  = f2;
    w[FLD3_LSB +: 10] = f3;
    return w;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant with pointer update (ptr 0 = A preferred).
// Ports: req_a/req_b in, update/force_en/force_b in, gnt_a/gnt_b out.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  input  logic force_en,
  input  logic force_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_q;

  assign gnt_a = req_a & (~req_b | ~ptr_q);
  assign gnt_b = req_b & (~req_a |  ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (force_en) begin
      ptr_q <= force_b;
    end else if (update) begin
      ptr_q <= gnt_a;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the node-table SRAM between requester A (loader) and B (traversal).
// Ports: a/b valid-ready request channels, a/b read return, SRAM pins.
// Optional macro SRAM_ARB_STARVE_EN bounds locked bursts to MAX_HOLD beats.
module sram_arbiter
  import bdd_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_valid,
  input  logic                  i_a_write,
  input  logic                  i_a_lock,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  input  logic                  i_b_valid,
  input  logic                  i_b_write,
  input  logic                  i_b_lock,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_a_ready,
  output logic                  o_a_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  output logic                  o_b_ready,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data
);

  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic gnt_a, gnt_b;
  logic a_xfer, b_xfer, xfer, rd_xfer;
  logic starve, a_lock, b_lock;
  logic pend_q, own_q;

  assign a_xfer  = o_a_ready;
  assign b_xfer  = o_b_ready;
  assign xfer    = a_xfer | b_xfer;
  assign rd_xfer = (a_xfer & ~i_a_write) |
                   (b_xfer & ~i_b_write);

`ifdef SRAM_ARB_STARVE_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q;

  // Hold count includes the beat that opened the burst.
  always_comb begin
    starve = 1'b0;
    if (hold_q >= HW'(MAX_HOLD - 1)) begin
      starve = (state_q == OWN_A && i_b_valid) ||
               (state_q == OWN_B && i_a_valid);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q <= '0;
    end else if (state_d == IDLE) begin
      hold_q <= '0;
    end else if (xfer && hold_q != HW'(MAX_HOLD)) begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign a_lock = i_a_lock & ~starve;
  assign b_lock = i_b_lock & ~starve;

  rr_arb2 u_rr (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .req_a    (i_a_valid),
    .req_b    (i_b_valid),
    .update   (state_q == IDLE && xfer),
    .force_en (starve && xfer),
    .force_b  (state_q == OWN_A),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b)
  );

  always_comb begin
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      IDLE: begin
        o_a_ready = gnt_a;
        o_b_ready = gnt_b;
        if (gnt_a && i_a_lock) begin
          state_d = OWN_A;
        end else if (gnt_b && i_b_lock) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        o_a_ready = i_a_valid;
        if (!i_a_valid || !a_lock) begin
          state_d = IDLE;
        end
      end
      OWN_B: begin
        o_b_ready = i_b_valid;
        if (!i_b_valid || !b_lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_sram_addr  = '0;
    o_sram_data  = '0;
    o_sram_write = 1'b0;
    unique case (1'b1)
      a_xfer: begin
        o_sram_addr  = i_a_addr;
        o_sram_data  = i_a_wdata;
        o_sram_write = i_a_write;
      end
      b_xfer: begin
        o_sram_addr  = i_b_addr;
        o_sram_data  = i_b_wdata;
        o_sram_write = i_b_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= rd_xfer;
      if (rd_xfer) begin
        own_q <= b_xfer;
      end
    end
  end

  assign o_a_rvalid = pend_q & ~own_q;
  assign o_b_rvalid = pend_q &  own_q;
  assign o_a_rdata  = i_sram_data;
  assign o_b_rdata  = i_sram_data;

  a_one_grant: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(o_a_ready && o_b_ready)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 1-cycle SRAM model.
// Read returns are checked against a queue filled at transfer time.
module tb_sram_arbiter;
  import bdd_pkg::*;

  localparam int AW = 4;
  localparam int DW = 34;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_write, a_lock;
  logic          b_valid, b_write, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, a_rvalid;
  logic          b_ready, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] s_addr;
  logic          s_write;
  logic [DW-1:0] s_wdata, s_rdata;

  sram_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_a_valid    (a_valid),
    .i_a_write    (a_write),
    .i_a_lock     (a_lock),
    .i_a_addr     (a_addr),
    .i_a_wdata    (a_wdata),
    .i_b_valid    (b_valid),
    .i_b_write    (b_write),
    .i_b_lock     (b_lock),
    .i_b_addr     (b_addr),
    .i_b_wdata    (b_wdata),
    .o_a_ready    (a_ready),
    .o_a_rvalid   (a_rvalid),
    .o_a_rdata    (a_rdata),
    .o_b_ready    (b_ready),
    .o_b_rvalid   (b_rvalid),
    .o_b_rdata    (b_rdata),
    .o_sram_addr  (s_addr),
    .o_sram_write (s_write),
    .o_sram_data  (s_wdata),
    .i_sram_data  (s_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (s_write) mem[s_addr] <= s_wdata;
    s_rdata <= mem[s_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic          side;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [16];

  // Each queued read must answer on exactly the next cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rv_side", {a_rvalid, b_rvalid},
            e.side ? 2'b01 : 2'b10);
        chk("rdata", e.side ? b_rdata : a_rdata, e.data);
      end else begin
        chk("rv_idle", {a_rvalid, b_rvalid}, 2'b00);
      end
      if (a_valid && a_ready) begin
        if (a_write) ref_mem[a_addr] = a_wdata;
        else sb.push_back({1'b0, ref_mem[a_addr]});
      end
      if (b_valid && b_ready) begin
        if (b_write) ref_mem[b_addr] = b_wdata;
        else sb.push_back({1'b1, ref_mem[b_addr]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] w [8];
  logic [DW-1:0] w3n;
  logic          exp_a;

  initial begin
    w[0] = node_word(8'd100, 8'd0, 8'd0, 10'd245);
    w[1] = node_word(8'd0, 8'd100, 8'd0, 10'd175);
    w[2] = node_word(8'd100, 8'd0, 8'd0, 10'd495);
    w[3] = node_word(8'd100, 8'd0, 8'd0, 10'd300);
    for (int i = 4; i < 8; i++)
      w[i] = node_word(8'(i), 8'(i + 1), 8'(i + 2), 10'(i * 10));
    w3n = node_word(8'd100, 8'd0, 8'd0, 10'd485);

    rst_n = 1'b0;
    {a_valid, a_write, a_lock} = '0;
    {b_valid, b_write, b_lock} = '0;
    a_addr = '0; b_addr = '0;
    a_wdata = '0; b_wdata = '0;
    #1;
    chk("rst_ready", {a_ready, b_ready}, 2'b00);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    chk("rst_swrite", s_write, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // A loads the table.
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_write = 1'b1;
      a_addr = AW'(i); a_wdata = w[i];
      #1;
      chk("wr_ready", a_ready, 1'b1);
      chk("wr_swrite", s_write, 1'b1);
      chk("wr_saddr", s_addr, AW'(i));
      chk("wr_sdata", s_wdata, w[i]);
      tick();
    end

    // Single A read.
    a_write = 1'b0; a_addr = 4'd0;
    #1;
    chk("rd0_ready", a_ready, 1'b1);
    chk("rd0_swrite", s_write, 1'b0);
    tick();
    a_valid = 1'b0;
    #1;
    chk("rd0_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    chk("rd0_data", a_rdata, w[0]);
    tick();

    // Lone B read moves the pointer back to A.
    b_valid = 1'b1; b_addr = 4'd2;
    #1;
    chk("b1_ready", b_ready, 1'b1);
    tick();

    // Both requesting: strict alternation.
    a_valid = 1'b1; a_addr = 4'd1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("alt_ready", {a_ready, b_ready},
          (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_saddr", s_addr,
          (k % 2 == 0) ? 4'd1 : 4'd2);
      tick();
    end

    // Lone A read points at B for the burst.
    b_valid = 1'b0;
    tick();
    a_addr = 4'd0;

    // B locked burst of 4 while A waits.
    b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_addr = AW'(4 + k);
      b_lock = (k < 3);
      #1;
      chk("brst_ready", {a_ready, b_ready}, 2'b01);
      tick();
    end
    b_valid = 1'b0; b_lock = 1'b0;
    #1;
    chk("brst_a5", a_ready, 1'b1);
    tick();

    // Reset pulse one cycle into an A locked burst.
    a_lock = 1'b1;
    tick();
    a_addr = 4'd1;
    #1;
    rst_n = 1'b0;
    a_valid = 1'b0; a_lock = 1'b0;
    #1;
    sb.delete();
    chk("mrst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    chk("mrst_ready", {a_ready, b_ready}, 2'b00);
    chk("mrst_swrite", s_write, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    a_valid = 1'b1; a_addr = 4'd1;
    b_valid = 1'b1; b_addr = 4'd2;
    #1;
    chk("post_rst_a", {a_ready, b_ready}, 2'b10);
    tick();
    #1;
    chk("post_rst_b", {a_ready, b_ready}, 2'b01);
    tick();

    // A holds a lock while B keeps asking.
    a_lock = 1'b1;
    for (int k = 0; k < 12; k++) begin
`ifdef SRAM_ARB_STARVE_EN
      exp_a = (k != 8);
`else
      exp_a = 1'b1;
`endif
      #1;
      chk("hold_ready", {a_ready, b_ready},
          {exp_a, ~exp_a});
      tick();
    end

    // Abandoned lock: one dead cycle, then B.
    a_valid = 1'b0; a_lock = 1'b0;
    #1;
    chk("aband_dead", {a_ready, b_ready}, 2'b00);
    tick();
    #1;
    chk("aband_b", b_ready, 1'b1);
    tick();
    b_valid = 1'b0;

    // Write then read the same word.
    a_valid = 1'b1; a_write = 1'b1;
    a_addr = 4'd3; a_wdata = w3n;
    #1;
    chk("wr3_swrite", s_write, 1'b1);
    tick();
    a_valid = 1'b0; a_write = 1'b0;
    b_valid = 1'b1; b_addr = 4'd3;
    #1;
    chk("rd3_ready", b_ready, 1'b1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("rd3_rvalid", {a_rvalid, b_rvalid}, 2'b01);
    chk("rd3_data", b_rdata, w3n);

    tick();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
